id_ex_stage_reg: RTL and testbench
==================================

Name: id_ex_stage_reg

Overview:
Parametrised ID/EX pipeline register for the MIPS datapath, and the successor of the fixed-width ID/EX register. It carries a generic control bundle and data bundle from decode to execute, with a valid bit, an external stall (hold) and flush (bubble). It also has built-in load-use hazard detection with bubble insertion, and saturating stall/bubble performance counters.

Parameters:
CTRL_W, 18, width of packed control bundle (WB/MEM/EX control fields)
DATA_W, 138, width of packed data bundle (PC+4, Read1, Read2, sign-extends)
REG_W, 5, register specifier width
MEMREAD_BIT, 4, index of the MemRead bit inside ID_Ctrl/EX_Ctrl
HAZARD_EN, 1, 1 = load-use detection active; 0 = HazardStall tied 0
CNT_W, 16, width of performance counters

Ports:
Clk  in  1  clock, all state on posedge
Rst  in  1  synchronous active-high reset
ID_Valid  in  1  decode stage holds a real instruction
ID_Ctrl  in  CTRL_W  decode control bundle
ID_Data  in  DATA_W  decode data bundle
ID_Rs  in  REG_W  source register 1 of the decode instruction
ID_Rt  in  REG_W  source register 2 of the decode instruction
ID_UsesRt  in  1  decode instruction reads Rt
ID_Rd  in  REG_W  final destination register, already RegDst-selected
Stall  in  1  external hold, e.g. a downstream multi-cycle unit
Flush  in  1  kill the decode instruction (branch/jump taken)
EX_Valid  out  1  execute stage holds a real instruction
EX_Ctrl  out  CTRL_W  registered control bundle
EX_Data  out  DATA_W  registered data bundle
EX_Rd  out  REG_W  registered destination register
HazardStall  out  1  combinational; freeze PC and IF/ID this cycle
BubbleCount  out  CNT_W  bubbles inserted by flush or hazard
StallCount  out  CNT_W  cycles held by external Stall

Behaviour:
- Reset: on a posedge with Rst=1, EX_Valid, EX_Ctrl, EX_Data, EX_Rd, BubbleCount and StallCount are all cleared to 0. Rst overrides every other input, including mid-stall or mid-hazard.
- Latency: 1 cycle from ID_* to EX_*.
- Hazard condition (combinational): H = HAZARD_EN & ID_Valid & EX_Valid & EX_Ctrl[MEMREAD_BIT] & (EX_Rd != 0) & ((EX_Rd == ID_Rs) | (ID_UsesRt & EX_Rd == ID_Rt)).
- HazardStall = H & ~Flush. Flush dominates because the decode instruction is discarded. HazardStall is independent of Stall.
- Per-posedge priority when Rst=0:
  1. Flush=1: EX_Valid<=0, EX_Ctrl<=0, EX_Data<=0, EX_Rd<=0; BubbleCount++. Flush overrides Stall.
  2. else Stall=1: all EX_* registers hold; StallCount++.
  3. else H=1: load a bubble (EX_Valid/Ctrl/Data/Rd <= 0); BubbleCount++.
  4. else normal load: EX_Valid<=ID_Valid. If ID_Valid=1, EX_Ctrl/EX_Data/EX_Rd <= ID_*. If ID_Valid=0, EX_Ctrl<=0, EX_Data<=0, EX_Rd<=0, and no counter increments.
- A bubble always has Ctrl all-zero. This guarantees no RegWrite/MemWrite/MemRead downstream.
- After a hazard bubble, EX_Valid=0, so H clears the next cycle. Upstream has held the instruction, which then loads normally. Load-use therefore costs exactly 1 bubble.
- Counters saturate at 2^CNT_W-1 and never wrap. They clear only on Rst.
- Rd/Rs value 0 never triggers a hazard ($zero).
- No combinational path from ID_* to EX_*. HazardStall is the only combinational output.

Test Plan:
- Reset: drive Rst=1 for 2 cycles with ID_Valid=1 and ID_Ctrl all-ones -> all outputs 0 after the first posedge; counters stay 0.
- Pass-through: ID_Valid=1, ID_Data=0x...DEAD, ID_Ctrl=0x155, ID_Rd=7 -> the next cycle EX_* show the same values and EX_Valid=1; HazardStall=0.
- Stall/flush: load instruction A, assert Stall for 3 cycles while ID changes to B -> EX holds A and StallCount=3. Then assert Stall and Flush together -> EX_Valid=0, Ctrl=0, BubbleCount=1, StallCount stays 3.
- Load-use: lw loaded (Ctrl[MEMREAD_BIT]=1, EX_Rd=8); decode presents ID_Rs=8 -> HazardStall=1 that cycle, next EX is a bubble, BubbleCount=1. The held add then loads with EX_Valid=1; HazardStall=0. Repeat with EX_Rd=0 or ID_UsesRt=0 and ID_Rt=8 -> no hazard.
- Hazard vs flush: hazard condition true with Flush=1 -> HazardStall=0; bubble counted once (BubbleCount +1, not +2).
- Saturation: CNT_W=2, assert Flush for 5 cycles -> BubbleCount sequence 1,2,3,3,3. Then Rst -> 0.

Source files
------------

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
// Holds on an external stall, kills the decode instruction on a flush, and
// keeps saturating counts of inserted bubbles and externally stalled cycles.
module id_ex_stage_reg #(
   parameter int CTRL_W      = 18,
   parameter int DATA_W      = 138,
   parameter int REG_W       = 5,
   parameter int MEMREAD_BIT = 4,
   parameter int HAZARD_EN   = 1,
   parameter int CNT_W       = 16
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              ID_Valid,
   input  logic [CTRL_W-1:0] ID_Ctrl,
   input  logic [DATA_W-1:0] ID_Data,
   input  logic [REG_W-1:0]  ID_Rs,
   input  logic [REG_W-1:0]  ID_Rt,
   input  logic              ID_UsesRt,
   input  logic [REG_W-1:0]  ID_Rd,
   input  logic              Stall,
   input  logic              Flush,
   output logic              EX_Valid,
   output logic [CTRL_W-1:0] EX_Ctrl,
   output logic [DATA_W-1:0] EX_Data,
   output logic [REG_W-1:0]  EX_Rd,
   output logic              HazardStall,
   output logic [CNT_W-1:0]  BubbleCount,
   output logic [CNT_W-1:0]  StallCount
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic              r_ex_valid;
   logic [CTRL_W-1:0] r_ex_ctrl;
   logic [DATA_W-1:0] r_ex_data;
   logic [REG_W-1:0]  r_ex_rd;
   logic [CNT_W-1:0]  r_bubble_cnt;
   logic [CNT_W-1:0]  r_stall_cnt;

   logic w_hazard;
   logic w_rs_match;
   logic w_rt_match;
   logic w_bubble;

   // Load-use detection: the load sitting in EX writes a register that the
   // instruction in decode reads. $zero is never a real dependency.
   always_comb begin
      w_rs_match  = (r_ex_rd == ID_Rs);
      w_rt_match  = ID_UsesRt && (r_ex_rd == ID_Rt);
      w_hazard    = (HAZARD_EN != 0) && ID_Valid && r_ex_valid &&
                    r_ex_ctrl[MEMREAD_BIT] && (r_ex_rd != '0) &&
                    (w_rs_match || w_rt_match);
      // A flushed decode instruction is discarded, so there is nothing to hold.
      HazardStall = w_hazard && !Flush;
      // Bubble inserted this edge: flush always, hazard only when not stalled.
      w_bubble    = Flush || (!Stall && w_hazard);
   end

   // Pipeline register: flush, then stall hold, then hazard bubble, then load.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_ex_valid <= 1'b0;
         r_ex_ctrl  <= '0;
         r_ex_data  <= '0;
         r_ex_rd    <= '0;
      end else if (Flush || (!Stall && w_hazard)) begin
         r_ex_valid <= 1'b0;
         r_ex_ctrl  <= '0;
         r_ex_data  <= '0;
         r_ex_rd    <= '0;
      end else if (!Stall) begin
         r_ex_valid <= ID_Valid;
         r_ex_ctrl  <= ID_Valid ? ID_Ctrl : '0;
         r_ex_data  <= ID_Valid ? ID_Data : '0;
         r_ex_rd    <= ID_Valid ? ID_Rd   : '0;
      end
   end

   // Saturating performance counters; a flush with stall counts as a bubble only.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_bubble_cnt <= '0;
         r_stall_cnt  <= '0;
      end else begin
         if (w_bubble && (r_bubble_cnt != CNT_MAX))
            r_bubble_cnt <= r_bubble_cnt + 1'b1;
         if (!Flush && Stall && (r_stall_cnt != CNT_MAX))
            r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign EX_Valid    = r_ex_valid;
   assign EX_Ctrl     = r_ex_ctrl;
   assign EX_Data     = r_ex_data;
   assign EX_Rd       = r_ex_rd;
   assign BubbleCount = r_bubble_cnt;
   assign StallCount  = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: directed steps with a scoreboard queue of
// expected EX-side values, plus a narrow-counter instance for saturation.
module tb_id_ex_stage_reg;

   localparam int CW = 18;
   localparam int DW = 138;
   localparam int RW = 5;
   localparam int MRB = 4;

   logic          Clk = 1'b0;
   logic          Rst;
   logic          ID_Valid;
   logic [CW-1:0] ID_Ctrl;
   logic [DW-1:0] ID_Data;
   logic [RW-1:0] ID_Rs, ID_Rt, ID_Rd;
   logic          ID_UsesRt;
   logic          Stall, Flush;

   logic          EX_Valid, HazardStall;
   logic [CW-1:0] EX_Ctrl;
   logic [DW-1:0] EX_Data;
   logic [RW-1:0] EX_Rd;
   logic [15:0]   BubbleCount, StallCount;

   logic          s_Valid, s_Hz;
   logic [CW-1:0] s_Ctrl;
   logic [DW-1:0] s_Data;
   logic [RW-1:0] s_Rd;
   logic [1:0]    s_Bubble, s_Stall;

   int total = 0;
   int bad   = 0;

   always #5 Clk = ~Clk;

   id_ex_stage_reg dut (
      .Clk(Clk), .Rst(Rst), .ID_Valid(ID_Valid), .ID_Ctrl(ID_Ctrl),
      .ID_Data(ID_Data), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
      .ID_Rd(ID_Rd), .Stall(Stall), .Flush(Flush), .EX_Valid(EX_Valid),
      .EX_Ctrl(EX_Ctrl), .EX_Data(EX_Data), .EX_Rd(EX_Rd),
      .HazardStall(HazardStall), .BubbleCount(BubbleCount), .StallCount(StallCount)
   );

   id_ex_stage_reg #(.CNT_W(2)) dut_sat (
      .Clk(Clk), .Rst(Rst), .ID_Valid(ID_Valid), .ID_Ctrl(ID_Ctrl),
      .ID_Data(ID_Data), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
      .ID_Rd(ID_Rd), .Stall(Stall), .Flush(Flush), .EX_Valid(s_Valid),
      .EX_Ctrl(s_Ctrl), .EX_Data(s_Data), .EX_Rd(s_Rd),
      .HazardStall(s_Hz), .BubbleCount(s_Bubble), .StallCount(s_Stall)
   );

   typedef struct {
      string         tag;
      logic          v;
      logic [CW-1:0] c;
      logic [DW-1:0] d;
      logic [RW-1:0] rd;
      logic [15:0]   bc;
      logic [15:0]   sc;
      logic [1:0]    sbc;
      logic [1:0]    ssc;
   } exp_t;

   exp_t sb[$];

   // reference state of the EX register as the bench expects it
   logic          m_v   = 1'b0;
   logic [CW-1:0] m_c   = '0;
   logic [DW-1:0] m_d   = '0;
   logic [RW-1:0] m_rd  = '0;
   logic [15:0]   m_bc  = '0;
   logic [15:0]   m_sc  = '0;
   logic [1:0]    m_sbc = '0;
   logic [1:0]    m_ssc = '0;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: check HazardStall, push the expected EX state, clock, pop and compare.
   task automatic step(input string tag);
      exp_t e;
      logic h;
      #1;
      h = ID_Valid && m_v && m_c[MRB] && (m_rd != 0) &&
          ((m_rd == ID_Rs) || (ID_UsesRt && (m_rd == ID_Rt)));
      chk({tag, ".hz"}, DW'(HazardStall), DW'(h && !Flush));
      if (Rst) begin
         m_v = 0; m_c = '0; m_d = '0; m_rd = '0;
         m_bc = '0; m_sc = '0; m_sbc = '0; m_ssc = '0;
      end else if (Flush || (!Stall && h)) begin
         m_v = 0; m_c = '0; m_d = '0; m_rd = '0;
         if (m_bc != 16'hFFFF) m_bc++;
         if (m_sbc != 2'd3) m_sbc++;
      end else if (Stall) begin
         if (m_sc != 16'hFFFF) m_sc++;
         if (m_ssc != 2'd3) m_ssc++;
      end else begin
         m_v  = ID_Valid;
         m_c  = ID_Valid ? ID_Ctrl : '0;
         m_d  = ID_Valid ? ID_Data : '0;
         m_rd = ID_Valid ? ID_Rd : '0;
      end
      e.tag = tag; e.v = m_v; e.c = m_c; e.d = m_d; e.rd = m_rd;
      e.bc = m_bc; e.sc = m_sc; e.sbc = m_sbc; e.ssc = m_ssc;
      sb.push_back(e);
      @(posedge Clk);
      #1;
      e = sb.pop_front();
      chk({e.tag, ".v"},   DW'(EX_Valid),    DW'(e.v));
      chk({e.tag, ".c"},   DW'(EX_Ctrl),     DW'(e.c));
      chk({e.tag, ".d"},   EX_Data,          e.d);
      chk({e.tag, ".rd"},  DW'(EX_Rd),       DW'(e.rd));
      chk({e.tag, ".bc"},  DW'(BubbleCount), DW'(e.bc));
      chk({e.tag, ".sc"},  DW'(StallCount),  DW'(e.sc));
      chk({e.tag, ".sbc"}, DW'(s_Bubble),    DW'(e.sbc));
      chk({e.tag, ".ssc"}, DW'(s_Stall),     DW'(e.ssc));
   endtask

   task automatic id_set(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                         input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                         input logic ut, input logic [RW-1:0] rd);
      ID_Valid = v; ID_Ctrl = c; ID_Data = d;
      ID_Rs = rs; ID_Rt = rt; ID_UsesRt = ut; ID_Rd = rd;
   endtask

   initial begin
      logic [DW-1:0] data_a;
      logic [DW-1:0] data_b;
      data_a = {10'h0, 128'h0123_4567_89AB_CDEF_0000_0000_0000_DEAD};
      data_b = {10'h3FF, 128'hFFFF_0000_1111_2222_3333_4444_5555_6666};
      Rst = 1; Stall = 0; Flush = 0;
      id_set(1'b1, '1, '1, 5'd1, 5'd2, 1'b1, 5'd31);

      // reset held two cycles against an all-ones decode bundle
      step("rst0");
      step("rst1");
      chk("rst_valid", DW'(EX_Valid), '0);
      chk("rst_bc", DW'(BubbleCount), '0);

      // pass-through
      Rst = 0;
      id_set(1'b1, 18'h155, data_a, 5'd1, 5'd2, 1'b1, 5'd7);
      step("pass");
      chk("pass_ctrl", DW'(EX_Ctrl), DW'(18'h155));
      chk("pass_data", EX_Data, data_a);
      chk("pass_rd", DW'(EX_Rd), DW'(5'd7));

      // decode bubble (ID_Valid=0) loads zeros and counts nothing
      id_set(1'b0, 18'h3FFFF, data_b, 5'd7, 5'd7, 1'b1, 5'd3);
      step("idle");

      // external stall holds A while decode changes to B
      id_set(1'b1, 18'h021, data_a, 5'd1, 5'd2, 1'b1, 5'd9);
      step("loadA");
      Stall = 1;
      id_set(1'b1, 18'h022, data_b, 5'd3, 5'd4, 1'b1, 5'd11);
      step("stall1");
      step("stall2");
      step("stall3");
      chk("stall_cnt", DW'(StallCount), DW'(16'd3));
      chk("stall_hold", EX_Data, data_a);
      Flush = 1;
      step("stallflush");
      chk("sf_valid", DW'(EX_Valid), '0);
      chk("sf_bc", DW'(BubbleCount), DW'(16'd1));
      chk("sf_sc", DW'(StallCount), DW'(16'd3));

      // load-use: lw r8 followed by a consumer of r8
      Stall = 0; Flush = 0;
      id_set(1'b1, 18'h010, data_a, 5'd1, 5'd2, 1'b1, 5'd8);
      step("lw");
      id_set(1'b1, 18'h003, data_b, 5'd8, 5'd2, 1'b1, 5'd10);
      #1;
      chk("lu_hz_on", DW'(HazardStall), DW'(1'b1));
      step("lu_bubble");
      chk("lu_bc", DW'(BubbleCount), DW'(16'd2));
      chk("lu_bub_valid", DW'(EX_Valid), '0);
      #1;
      chk("lu_hz_off", DW'(HazardStall), '0);
      step("lu_add");
      chk("lu_add_rd", DW'(EX_Rd), DW'(5'd10));

      // lw to $zero never hazards
      id_set(1'b1, 18'h010, data_a, 5'd1, 5'd2, 1'b1, 5'd0);
      step("lw_r0");
      id_set(1'b1, 18'h003, data_b, 5'd0, 5'd0, 1'b1, 5'd12);
      step("use_r0");

      // Rt matches but is not read
      id_set(1'b1, 18'h010, data_a, 5'd1, 5'd2, 1'b1, 5'd8);
      step("lw_r8b");
      id_set(1'b1, 18'h003, data_b, 5'd3, 5'd8, 1'b0, 5'd13);
      step("no_rt");
      chk("no_rt_valid", DW'(EX_Valid), DW'(1'b1));

      // Rt matches and is read
      id_set(1'b1, 18'h010, data_a, 5'd1, 5'd2, 1'b1, 5'd8);
      step("lw_r8c");
      id_set(1'b1, 18'h003, data_b, 5'd3, 5'd8, 1'b1, 5'd14);
      step("rt_bubble");
      chk("rt_bc", DW'(BubbleCount), DW'(16'd3));
      step("rt_add");

      // hazard coincident with flush: one bubble, no HazardStall
      id_set(1'b1, 18'h010, data_a, 5'd1, 5'd2, 1'b1, 5'd8);
      step("lw_r8d");
      id_set(1'b1, 18'h003, data_b, 5'd8, 5'd2, 1'b1, 5'd15);
      Flush = 1;
      #1;
      chk("hf_hz", DW'(HazardStall), '0);
      step("hf");
      chk("hf_bc", DW'(BubbleCount), DW'(16'd4));

      // saturation on the 2-bit counter instance
      Flush = 0; Rst = 1;
      step("sat_rst");
      Rst = 0; Flush = 1;
      step("sat1"); chk("sat_1", DW'(s_Bubble), DW'(2'd1));
      step("sat2"); chk("sat_2", DW'(s_Bubble), DW'(2'd2));
      step("sat3"); chk("sat_3", DW'(s_Bubble), DW'(2'd3));
      step("sat4"); chk("sat_4", DW'(s_Bubble), DW'(2'd3));
      step("sat5"); chk("sat_5", DW'(s_Bubble), DW'(2'd3));
      Flush = 0; Rst = 1;
      step("sat_clr");
      chk("sat_clr_bc", DW'(s_Bubble), '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // watchdog so the run always ends
   initial begin
      #20000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
